// File: rtl/tt_mem_port.sv
// ---------------------------------------------------------------------------
// tt_mem_port
//   Byte-serial memory initiator. Bridges the core's word-wide request port
//   to an external responder over the TinyTapeout uio pins: each request is
//   sent as a strobed byte frame (command, address LSB first, and write data
//   LSB first for writes), then the response byte(s) are collected from the
//   dedicated inputs. A watchdog aborts a transaction whose responder goes
//   silent, so the core always gets exactly one response per request.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we/addr/wdata   request fields, latched on acceptance
//   rsp_valid           one-cycle response pulse
//   rsp_rdata/rsp_err   response payload, held until the next response
//   bus_out/bus_oe      frame byte and pin direction (uio_out / uio_oe)
//   bus_strobe          frame byte qualifier
//   bus_in/bus_in_valid response byte and its qualifier (ui_in)
// ---------------------------------------------------------------------------
module tt_mem_port #(
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] CMD_RD  = 8'h01,
    parameter logic [7:0] CMD_WR  = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        bus_strobe,
    input  logic [7:0]  bus_in,
    input  logic        bus_in_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WAIT, S_RDATA, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] wdog_q, wdog_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic [7:0]  bus_oe_q, bus_oe_d;
    logic        bus_strobe_q, bus_strobe_d;

    // Datapath registers: no reset needed, always loaded before use.
    logic        we_q, we_d;
    logic [63:0] sh_q, sh_d;      // {wdata, addr}, shifted out a byte at a time
    logic [31:0] acc_q, acc_d;    // read bytes, shifted in from the top

    // The count would reach TIMEOUT at the end of this cycle.
    logic wdog_hit;
    assign wdog_hit = (({1'b0, wdog_q} + 17'd1) == 17'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wdog_d       = wdog_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        bus_out_d    = 8'h00;
        bus_oe_d     = 8'h00;
        bus_strobe_d = 1'b0;
        we_d         = we_q;
        sh_d         = sh_q;
        acc_d        = acc_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    sh_d         = {req_wdata, req_addr};
                    state_d      = S_CMD;
                    bus_out_d    = req_we ? CMD_WR : CMD_RD;
                    bus_strobe_d = 1'b1;
                    bus_oe_d     = 8'hFF;
                end
            end
            S_CMD: begin
                state_d      = S_ADDR;
                cnt_d        = 2'd0;
                bus_out_d    = sh_q[7:0];
                bus_strobe_d = 1'b1;
                bus_oe_d     = 8'hFF;
                sh_d         = {8'h00, sh_q[63:8]};
            end
            S_ADDR, S_WDATA: begin
                if (cnt_q == 2'd3 && (state_q == S_WDATA || !we_q)) begin
                    // Frame complete: release the pins and start listening.
                    state_d = S_WAIT;
                    cnt_d   = 2'd0;
                    wdog_d  = 16'd0;
                end else begin
                    if (cnt_q == 2'd3) state_d = S_WDATA;
                    cnt_d        = cnt_q + 2'd1;
                    bus_out_d    = sh_q[7:0];
                    bus_strobe_d = 1'b1;
                    bus_oe_d     = 8'hFF;
                    sh_d         = {8'h00, sh_q[63:8]};
                end
            end
            S_WAIT, S_RDATA: begin
                if (bus_in_valid) begin
                    wdog_d = 16'd0;
                    if (we_q) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = bus_in[0];
                        rsp_rdata_d = 32'd0;
                    end else begin
                        acc_d = {bus_in, acc_q[31:8]};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d     = S_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                            rsp_rdata_d = {bus_in, acc_q[31:8]};
                        end else begin
                            state_d = S_RDATA;
                        end
                    end
                end else if (wdog_hit) begin
                    // Responder went silent: abort, dropping any partial data.
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            wdog_q       <= 16'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_err_q    <= 1'b0;
            bus_out_q    <= 8'h00;
            bus_oe_q     <= 8'h00;
            bus_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wdog_q       <= wdog_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            bus_out_q    <= bus_out_d;
            bus_oe_q     <= bus_oe_d;
            bus_strobe_q <= bus_strobe_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q  <= we_d;
        sh_q  <= sh_d;
        acc_q <= acc_d;
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign bus_out    = bus_out_q;
    assign bus_oe     = bus_oe_q;
    assign bus_strobe = bus_strobe_q;

endmodule

// File: tb/tb_tt_mem_port.sv
module tb_tt_mem_port;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic        bus_strobe;
    logic [7:0]  bus_in;
    logic        bus_in_valid;

    int total = 0;
    int bad   = 0;

    // Per-cycle responder schedule, indexed by cycle after the accept edge.
    logic       sv [0:1023];
    logic [7:0] sb [0:1023];

    tt_mem_port #(.TIMEOUT(TO), .CMD_RD(8'h01), .CMD_WR(8'h02)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_strobe(bus_strobe),
        .bus_in(bus_in), .bus_in_valid(bus_in_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. bytes: responder bytes (byte i at [8i+:8]);
    // gaps: idle cycles before each byte (gap i at [8i+:8]); n: bytes offered.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int n, input logic [31:0] bytes, input logic [31:0] gaps,
                           input bit noise);
        int L, need, s, exp_rsp, got_rsp, c, budget, pin_bad, rdy_bad, last_st, g;
        bit done, seen;
        logic        exp_err, got_err;
        logic [31:0] exp_rdata, got_rdata;
        logic [7:0]  exp_frame[$];
        logic [7:0]  got_frame[$];
        logic [63:0] gb;

        L       = we ? 9 : 5;
        need    = we ? 1 : 4;
        s       = L + 1;
        done    = 0;
        exp_rsp = 0;
        exp_err = 1'b0;
        exp_rdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin sv[i] = 1'b0; sb[i] = 8'h00; end
        if (noise)
            for (int i = 1; i <= L; i++) begin sv[i] = 1'($urandom_range(0, 1)); sb[i] = 8'($urandom); end

        // Reference: walk the responder bytes window by window.
        for (int i = 0; i < need; i++) begin
            if (!done) begin
                g = int'(gaps[8*i +: 8]);
                if (i >= n || g >= TO) begin
                    exp_rsp   = s + TO;
                    exp_err   = 1'b1;
                    exp_rdata = 32'd0;
                    done      = 1;
                end else begin
                    sv[s + g] = 1'b1;
                    sb[s + g] = bytes[8*i +: 8];
                    s = s + g + 1;
                end
            end
        end
        if (!done) begin
            exp_rsp   = s;
            exp_err   = we ? bytes[0] : 1'b0;
            exp_rdata = we ? 32'd0 : bytes;
        end

        exp_frame.push_back(we ? 8'h02 : 8'h01);
        for (int k = 0; k < 4; k++) exp_frame.push_back(addr[8*k +: 8]);
        if (we) for (int k = 0; k < 4; k++) exp_frame.push_back(wdata[8*k +: 8]);

        check_val("ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        c = 1; seen = 0; pin_bad = 0; rdy_bad = 0; last_st = 0; got_rsp = 0;
        got_err = 1'b0; got_rdata = 32'd0;
        budget = L + 4 * (TO + 2) + 10;
        while (!seen && c <= budget) begin
            if (bus_strobe) begin got_frame.push_back(bus_out); last_st = c; end
            if (bus_oe !== (bus_strobe ? 8'hFF : 8'h00) || (!bus_strobe && bus_out !== 8'h00)) pin_bad++;
            if (req_ready !== 1'b0) rdy_bad++;
            if (rsp_valid) begin
                seen = 1; got_rsp = c; got_err = rsp_err; got_rdata = rsp_rdata;
            end else begin
                bus_in_valid = sv[c]; bus_in = sb[c];
                tick;
                c++;
            end
        end
        bus_in_valid = 1'b0; bus_in = 8'h00;

        check_val("rsp_seen", {63'd0, seen}, 64'd1);
        check_val("rsp_cycle", 64'(got_rsp), 64'(exp_rsp));
        check_val("rsp_err", {63'd0, got_err}, {63'd0, exp_err});
        check_val("rsp_rdata", {32'd0, got_rdata}, {32'd0, exp_rdata});
        check_val("frame_len", 64'(got_frame.size()), 64'(L));
        check_val("frame_last_cycle", 64'(last_st), 64'(L));
        for (int k = 0; k < exp_frame.size(); k++) begin
            gb = (k < got_frame.size()) ? {56'd0, got_frame[k]} : 64'hx;
            check_val($sformatf("frame_byte%0d", k), gb, {56'd0, exp_frame[k]});
        end
        check_val("pin_dir", 64'(pin_bad), 64'd0);
        check_val("ready_busy", 64'(rdy_bad), 64'd0);

        if (seen) begin
            tick;
            check_val("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
            check_val("ready_after", {63'd0, req_ready}, 64'd1);
            check_val("rdata_hold", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
            check_val("err_hold", {63'd0, rsp_err}, {63'd0, exp_err});
        end else begin
            rst = 1'b1; tick; rst = 1'b0; tick;
        end
    endtask

    task automatic reset_mid_test;
        int pulses;
        check_val("rm_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hCAFE_0004; req_wdata = 32'h0BAD_F00D;
        tick;
        req_valid = 1'b0;
        tick; tick; tick;  // cycle 4: third address byte
        check_val("rm_strobe_before", {56'd0, bus_out}, 64'hFE);
        #1 rst = 1'b1;
        #1;
        check_val("rm_oe_now", {56'd0, bus_oe}, 64'd0);
        check_val("rm_strobe_now", {63'd0, bus_strobe}, 64'd0);
        tick; tick;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) pulses++;
            bus_in_valid = 1'($urandom_range(0, 1)); bus_in = 8'($urandom);
            tick;
        end
        bus_in_valid = 1'b0;
        check_val("rm_no_rsp", 64'(pulses), 64'd0);
        check_val("rm_ready_after", {63'd0, req_ready}, 64'd1);
        check_val("rm_oe_after", {56'd0, bus_oe}, 64'd0);
    endtask

    initial begin
        logic        we;
        int          n, r;
        logic [31:0] gp;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        bus_in = 8'h00; bus_in_valid = 1'b0;
        #2;
        check_val("rst_ready", {63'd0, req_ready}, 64'd1);
        check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_val("rst_err", {63'd0, rsp_err}, 64'd0);
        check_val("rst_bus_out", {56'd0, bus_out}, 64'd0);
        check_val("rst_bus_oe", {56'd0, bus_oe}, 64'd0);
        check_val("rst_strobe", {63'd0, bus_strobe}, 64'd0);
        tick; tick;
        rst = 1'b0;
        tick;

        // Write, immediate OK ack.
        run_txn(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1, 32'h0000_0000, 32'h0000_0000, 0);
        // Read with 2-cycle gaps.
        run_txn(1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4, 32'h1234_5678, 32'h0202_0202, 0);
        // Write NAK, then a read accepted in the very next idle cycle.
        run_txn(1'b1, 32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0001, 32'h0000_0003, 0);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 4, 32'hA1B2_C3D4, 32'h0000_0000, 0);
        // Only 2 read bytes arrive: watchdog expires.
        run_txn(1'b0, 32'h0000_0030, 32'h0, 2, 32'h0000_BBAA, 32'h0000_0301, 0);
        // Bytes landing on the last watchdog cycle are accepted.
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4, 32'h4433_2211, 32'h0700_0707, 0);
        // Write with no ack at all.
        run_txn(1'b1, 32'h0000_0050, 32'h5555_AAAA, 0, 32'h0, 32'h0, 0);
        // Response-byte noise during the outgoing frame is ignored.
        run_txn(1'b0, 32'h0000_0060, 32'h0, 4, 32'hCAFE_BABE, 32'h0001_0000, 1);

        reset_mid_test();

        for (int t = 0; t < 30; t++) begin
            we = 1'($urandom);
            n  = (!we && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : 4;
            if (we && $urandom_range(0, 9) == 0) n = 0;
            gp = 32'd0;
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)       gp[8*i +: 8] = 8'($urandom_range(0, 2));
                else if (r < 8)  gp[8*i +: 8] = 8'(TO - 1);
                else if (r == 8) gp[8*i +: 8] = 8'(TO);
                else             gp[8*i +: 8] = 8'($urandom_range(3, 5));
            end
            run_txn(we, $urandom, $urandom, n, $urandom, gp, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
